loop_sequencer: RTL

//  Initiator side of the perf_sys loop-limit interface. Drives the running

---
 rtl/loop_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/loop_sequencer.sv
// loop_sequencer
//   Initiator side of the perf_sys loop-limit interface. Steps a workload one
//   iteration at a time over a req/ack handshake, lets the loop limiter settle,
//   then commits the limiter's incremented count. A run ends on target reached,
//   limiter fail, ack timeout, bad count or abort.
//
// Ports
//   clk                     in   rising-edge clock
//   reset                   in   asynchronous, active-high
//   start                   in   1-cycle pulse, begins a run when idle
//   abort                   in   level, cancels the active run
//   target_loops    [15:0]  in   iterations requested, sampled on accepted start
//   iter_ack                in   workload finished current iteration
//   current_loop_actualize  in   limiter's incremented count (0 = rejected)
//   limit_fail              in   limiter fail flag
//   current_loop    [15:0]  out  committed loop count to limiter
//   stop                    out  1 = limiter halted, 0 = limiter checking
//   iter_req                out  request one workload iteration
//   busy                    out  run in progress
//   done                    out  1-cycle pulse, target reached
//   error                   out  sticky, run ended abnormally
//   error_code      [1:0]   out  00 none, 01 limit, 10 ack timeout, 11 bad count
//   loops_done      [15:0]  out  final committed count of last run
//
// state  | meaning
// S_IDLE   | waiting for start
// S_ISSUE  | iter_req high, ack timer running
// S_SETTLE | waiting for limiter outputs, then sample once
// S_DONE   | target reached, done pulse
// S_FAIL   | run ended abnormally, error raised
module loop_sequencer #(
  parameter int LIM_LAT     = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] target_loops,
  input  logic        iter_ack,
  input  logic [15:0] current_loop_actualize,
  input  logic        limit_fail,
  output logic [15:0] current_loop,
  output logic        stop,
  output logic        iter_req,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [15:0] loops_done
);

  localparam int SW = (LIM_LAT < 1) ? 1 : $clog2(LIM_LAT + 1);
  localparam logic [SW-1:0] LAT_LOAD = SW'(LIM_LAT);
  // Down-counter: ISSUE lasts at most ACK_TIMEOUT cycles (terminal count 0).
  localparam logic [7:0]    ACK_LOAD = 8'(ACK_TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_LIMIT = 2'b01;
  localparam logic [1:0] CODE_TMO   = 2'b10;
  localparam logic [1:0] CODE_BAD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     target_q, target_nx;
  logic [15:0]     cur_nx, ld_nx;
  logic [7:0]      ack_tmr, ack_nx;
  logic [SW-1:0]   set_tmr, set_nx;
  logic            err_nx;
  logic [1:0]      code_nx;
  logic            count_ok;

  // 17-bit compare so a count of 0xFFFF never matches a wrapped 0.
  assign count_ok = ({1'b0, current_loop_actualize} == ({1'b0, current_loop} + 17'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      target_q     <= '0;
      current_loop <= '0;
      loops_done   <= '0;
      ack_tmr      <= '0;
      set_tmr      <= '0;
      error        <= 1'b0;
      error_code   <= CODE_NONE;
    end else begin
      state        <= state_nx;
      target_q     <= target_nx;
      current_loop <= cur_nx;
      loops_done   <= ld_nx;
      ack_tmr      <= ack_nx;
      set_tmr      <= set_nx;
      error        <= err_nx;
      error_code   <= code_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target_q;
    cur_nx    = current_loop;
    ld_nx     = loops_done;
    ack_nx    = ack_tmr;
    set_nx    = set_tmr;
    err_nx    = error;
    code_nx   = error_code;

    case (state)
      S_IDLE: begin
        if (start) begin
          target_nx = target_loops;
          cur_nx    = '0;
          err_nx    = 1'b0;
          code_nx   = CODE_NONE;
          if (target_loops == 16'd0) begin
            ld_nx    = '0;
            state_nx = S_DONE;
          end else begin
            ack_nx   = ACK_LOAD;
            state_nx = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (abort) begin
          ld_nx    = current_loop;
          err_nx   = 1'b0;
          code_nx  = CODE_NONE;
          state_nx = S_IDLE;
        end else if (iter_ack) begin
          // An ack arriving on the last allowed cycle still counts.
          set_nx   = LAT_LOAD;
          state_nx = S_SETTLE;
        end else if (ack_tmr == 8'd0) begin
          err_nx   = 1'b1;
          code_nx  = CODE_TMO;
          state_nx = S_FAIL;
        end else begin
          ack_nx = ack_tmr - 8'd1;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          ld_nx    = current_loop;
          err_nx   = 1'b0;
          code_nx  = CODE_NONE;
          state_nx = S_IDLE;
        end else if (set_tmr != '0) begin
          set_nx = set_tmr - SW'(1);
        end else if (limit_fail) begin
          err_nx   = 1'b1;
          code_nx  = CODE_LIMIT;
          state_nx = S_FAIL;
        end else if (!count_ok) begin
          err_nx   = 1'b1;
          code_nx  = CODE_BAD;
          state_nx = S_FAIL;
        end else begin
          cur_nx = current_loop_actualize;
          if (current_loop_actualize == target_q) begin
            state_nx = S_DONE;
          end else begin
            ack_nx   = ACK_LOAD;
            state_nx = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        ld_nx    = current_loop;
        state_nx = S_IDLE;
      end

      S_FAIL: begin
        ld_nx    = current_loop;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign busy     = (state == S_ISSUE) || (state == S_SETTLE);
  assign stop     = !busy;
  assign iter_req = (state == S_ISSUE);
  assign done     = (state == S_DONE);

endmodule
